// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared FSM state encoding and counter width helper for the multipliers
package mult_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Width of a counter that must hold values 0..width inclusive
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// rtl/booth_addsub.sv - N-bit ripple adder/subtractor built from full-adder cells
module booth_addsub #(
  parameter int N = 9
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] s
);

  logic [N-1:0] w_y;
  logic [N-1:0] w_c;

  // Subtraction is x + ~y + 1: invert y and feed sub in as the carry-in
  assign w_y    = y ^ {N{sub}};
  assign w_c[0] = sub;

  // Full-adder chain; the carry out of the top cell is not needed
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i] = x[i] ^ w_y[i] ^ w_c[i];
    if (i < N - 1) begin : g_carry
      assign w_c[i+1] = (x[i] & w_y[i]) | (w_c[i] & (x[i] ^ w_y[i]));
    end
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - iterative signed radix-2 Booth multiplier, one step per clock
module booth_seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             r_state;
  logic [WIDTH:0]     r_acc;
  logic [WIDTH:0]     r_m;
  logic [WIDTH-1:0]   r_q;
  logic               r_q1;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic               w_sub;
  logic               w_do_op;
  logic               w_last;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_acc_step;

  // Booth pair {Q0,q_1}: 10 subtracts M, 01 adds M, 00/11 leave Acc alone
  assign w_sub      = r_q[0] & ~r_q1;
  assign w_do_op    = r_q[0] ^ r_q1;
  assign w_acc_step = w_do_op ? w_sum : r_acc;
  assign w_last     = (r_cnt == CNT_W'(WIDTH));

  booth_addsub #(
    .N (WIDTH + 1)
  ) u_addsub (
    .x   (r_acc),
    .y   (r_m),
    .sub (w_sub),
    .s   (w_sum)
  );

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign product   = r_product;

  // FSM, Booth step/shift datapath and product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_q1      <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_m     <= {a[WIDTH-1], a};
            r_q     <= b;
            r_acc   <= '0;
            r_q1    <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_last) begin
            // Acc[WIDTH] is only a sign guard; the exact product fits in 2*WIDTH bits
            r_product <= {r_acc[WIDTH-1:0], r_q};
            r_state   <= ST_DONE;
          end else begin
            r_acc <= {w_acc_step[WIDTH], w_acc_step[WIDTH:1]};
            r_q   <= {w_acc_step[0], r_q[WIDTH-1:1]};
            r_q1  <= r_q[0];
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb/tb_booth_seq_multiplier.sv - directed and random checks of booth_seq_multiplier at WIDTH 4, 8, 16
module tb_booth_seq_multiplier;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic        iv4, ir4, ov4, or4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        iv8, ir8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv16, ir16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  booth_seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .product(p4)
  );

  booth_seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .product(p8)
  );

  booth_seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .product(p16)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic get_ov(input int w);
    case (w)
      4:       return ov4;
      16:      return ov16;
      default: return ov8;
    endcase
  endfunction

  function automatic logic get_ir(input int w);
    case (w)
      4:       return ir4;
      16:      return ir16;
      default: return ir8;
    endcase
  endfunction

  function automatic logic [31:0] get_prod(input int w);
    case (w)
      4:       return {24'b0, p4};
      16:      return p16;
      default: return {16'b0, p8};
    endcase
  endfunction

  task automatic set_in(input int w, input logic v, input longint av, input longint bv);
    case (w)
      4:       begin iv4  = v; a4  = av[3:0];  b4  = bv[3:0];  end
      16:      begin iv16 = v; a16 = av[15:0]; b16 = bv[15:0]; end
      default: begin iv8  = v; a8  = av[7:0];  b8  = bv[7:0];  end
    endcase
  endtask

  task automatic set_ordy(input int w, input logic v);
    case (w)
      4:       or4  = v;
      16:      or16 = v;
      default: or8  = v;
    endcase
  endtask

  // Signed reference product truncated to 2*w bits
  function automatic logic [31:0] ref_mul(input int w, input longint av, input longint bv);
    longint p;
    longint mask;
    p    = av * bv;
    mask = (longint'(1) << (2 * w)) - 1;
    p    = p & mask;
    return p[31:0];
  endfunction

  function automatic longint rnd_s(input int w);
    longint x;
    x = longint'($urandom_range((1 << w) - 1, 0));
    if (x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
    return x;
  endfunction

  // Present operands for one cycle; returns #1 after the accept edge
  task automatic start_op(input int w, input longint av, input longint bv);
    @(negedge clk);
    set_in(w, 1'b1, av, bv);
    @(posedge clk);
    #1;
    set_in(w, 1'b0, 0, 0);
  endtask

  // Counts clock edges from the accept edge until out_valid, bounded
  task automatic wait_valid(input int w, output int lat, output int ir_hi);
    lat   = 0;
    ir_hi = 0;
    while (!get_ov(w) && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (get_ir(w)) ir_hi++;
    end
  endtask

  task automatic handshake(input int w);
    @(negedge clk);
    set_ordy(w, 1'b1);
    @(posedge clk);
    #1;
    set_ordy(w, 1'b0);
  endtask

  task automatic run_op(input int w, input longint av, input longint bv, input string tag,
                        input logic [31:0] exp, input int stall);
    int lat;
    int irh;
    int bad;
    start_op(w, av, bv);
    wait_valid(w, lat, irh);
    check_eq({tag, " product"}, get_prod(w), exp);
    check_eq({tag, " latency"}, lat, w + 1);
    check_eq({tag, " in_ready busy"}, irh, 0);
    bad = 0;
    repeat (stall) begin
      @(posedge clk);
      #1;
      if (get_ov(w) !== 1'b1 || get_prod(w) !== exp) bad++;
    end
    check_eq({tag, " stall hold"}, bad, 0);
    handshake(w);
    check_eq({tag, " out_valid drop"}, get_ov(w), 0);
  endtask

  initial begin
    int lat;
    int irh;
    int bad;
    longint xa;
    longint xb;
    int widths [3];

    rst_n = 1'b0;
    set_in(4, 1'b0, 0, 0);
    set_in(8, 1'b0, 0, 0);
    set_in(16, 1'b0, 0, 0);
    set_ordy(4, 1'b0);
    set_ordy(8, 1'b0);
    set_ordy(16, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset in_ready", ir8, 1);
    check_eq("reset out_valid", ov8, 0);
    check_eq("reset product", p8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8, 3, -5, "t1 3*-5", 32'h0000FFF1, 0);
    run_op(8, -128, -128, "t2 -128*-128", 32'h00004000, 0);
    run_op(8, -128, 127, "t2 -128*127", 32'h0000C080, 0);
    run_op(8, 127, 127, "t2 127*127", 32'h00003F01, 0);
    run_op(8, 0, -1, "t3 0*-1", 32'h00000000, 0);
    run_op(8, -1, 1, "t3 -1*1", 32'h0000FFFF, 0);

    // Back-pressure: DONE held for 20 cycles while new operands are offered
    start_op(8, -7, 6);
    wait_valid(8, lat, irh);
    check_eq("t4 product", p8, 32'h0000FFD6);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      set_in(8, 1'b1, 5, 5);
      @(posedge clk);
      #1;
      if (ov8 !== 1'b1 || p8 !== 16'hFFD6 || ir8 !== 1'b0) bad++;
    end
    check_eq("t4 hold stable", bad, 0);
    handshake(8);
    check_eq("t4 idle out_valid", ov8, 0);
    check_eq("t4 idle in_ready", ir8, 1);
    @(posedge clk);
    #1;
    set_in(8, 1'b0, 0, 0);
    wait_valid(8, lat, irh);
    check_eq("t4 next product", p8, 32'h00000019);
    check_eq("t4 next latency", lat, 9);
    handshake(8);

    // Reset asserted mid-RUN after step 4
    start_op(8, 7, 9);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t5 async in_ready", ir8, 1);
    check_eq("t5 async out_valid", ov8, 0);
    check_eq("t5 async product", p8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (ov8 !== 1'b0) bad++;
    end
    check_eq("t5 no aborted product", bad, 0);
    run_op(8, -6, 11, "t5 -6*11", 32'h0000FFBE, 0);

    // Random operands with random consumer stalls at three widths
    widths[0] = 4;
    widths[1] = 8;
    widths[2] = 16;
    foreach (widths[k]) begin
      for (int i = 0; i < 10; i++) begin
        if (i == 0) begin
          xa = -(longint'(1) << (widths[k] - 1));
          xb = xa;
        end else begin
          xa = rnd_s(widths[k]);
          xb = rnd_s(widths[k]);
        end
        run_op(widths[k], xa, xb, $sformatf("rnd w%0d %0d*%0d", widths[k], xa, xb),
               ref_mul(widths[k], xa, xb), $urandom_range(3, 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
